// File: rtl/disk_arbiter.sv
// Two-requester arbiter in front of a single disk_dev: grants ownership, muxes
// the sector buffer port and sequences one read/write sector operation at a time.
module disk_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  start,
    input  logic [1:0]  op,
    input  logic [57:0] sector,
    input  logic [1:0]  buf_we,
    input  logic [17:0] addr,
    input  logic [63:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [31:0] dev_instruction,
    output logic        dev_read_pause,
    output logic        dev_write_pause,
    output logic [8:0]  dev_addr,
    output logic [31:0] dev_data_in,
    input  logic [31:0] dev_data_out,
    input  logic        dev_operate_done,
    output logic        dev_abort
);

    localparam int unsigned SEC_W   = 29;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMER_W = 32;
    localparam logic [TIMER_W-1:0] TIMER_LIMIT =
        (TIMEOUT_CYCLES == 0) ? TIMER_W'(0) : TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, ISSUE, BUSY} state_t;

    state_t             state, state_d;
    logic               owner, owner_d;
    logic               last_grant, last_grant_d;
    logic               op_l, op_l_d;
    logic [SEC_W-1:0]   sector_l, sector_l_d;
    logic [TIMER_W-1:0] timer, timer_d;
    logic [1:0]         gnt_d, done_d, err_d;
    logic               read_pause_d, write_pause_d, abort_d;

    logic               win;
    logic               op_done_ok;
    logic               timeout_hit;
    logic               finish;
    logic               owner_req;
    logic               owner_start;
    logic               owner_op;
    logic [SEC_W-1:0]   owner_sector;

    // Round-robin: a lone requester wins, a tie goes to whoever was not granted last.
    assign win          = req[1] & (~req[0] | ~last_grant);
    assign owner_req    = req[owner];
    assign owner_start  = start[owner];
    assign owner_op     = op[owner];
    assign owner_sector = owner ? sector[2*SEC_W-1:SEC_W] : sector[SEC_W-1:0];

    // The first BUSY cycle (timer == 0) masks a stale done left over from the last operation.
    assign op_done_ok  = (state == BUSY) && (timer != '0) && dev_operate_done;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == BUSY) &&
                         (timer == TIMER_LIMIT) && !op_done_ok;
    assign finish      = op_done_ok | timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            op_l            <= 1'b0;
            sector_l        <= '0;
            timer           <= '0;
            gnt             <= '0;
            done            <= '0;
            err             <= '0;
            dev_read_pause  <= 1'b0;
            dev_write_pause <= 1'b0;
            dev_abort       <= 1'b0;
        end else begin
            state           <= state_d;
            owner           <= owner_d;
            last_grant      <= last_grant_d;
            op_l            <= op_l_d;
            sector_l        <= sector_l_d;
            timer           <= timer_d;
            gnt             <= gnt_d;
            done            <= done_d;
            err             <= err_d;
            dev_read_pause  <= read_pause_d;
            dev_write_pause <= write_pause_d;
            dev_abort       <= abort_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|req) state_d = OWN;
            OWN: begin
                if (!owner_req)       state_d = IDLE;
                else if (owner_start) state_d = ISSUE;
            end
            ISSUE:   state_d = BUSY;
            BUSY:    if (finish) state_d = owner_req ? OWN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        owner_d       = owner;
        last_grant_d  = last_grant;
        op_l_d        = op_l;
        sector_l_d    = sector_l;
        timer_d       = timer;
        gnt_d         = gnt;
        done_d        = '0;
        err_d         = err;
        read_pause_d  = 1'b0;
        write_pause_d = 1'b0;
        abort_d       = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_d      = win;
                    last_grant_d = win;
                    gnt_d        = win ? 2'b10 : 2'b01;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    gnt_d = '0;
                end else if (owner_start) begin
                    op_l_d        = owner_op;
                    sector_l_d    = owner_sector;
                    err_d[owner]  = 1'b0;
                    write_pause_d = owner_op;
                    read_pause_d  = ~owner_op;
                end
            end
            ISSUE: begin
                timer_d = '0;
            end
            BUSY: begin
                if (timer != '1) timer_d = timer + TIMER_W'(1);
                if (finish) begin
                    done_d[owner] = 1'b1;
                    if (timeout_hit) begin
                        abort_d      = 1'b1;
                        err_d[owner] = 1'b1;
                    end
                    if (!owner_req) gnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        dev_instruction = '0;
        case (state)
            OWN:         dev_instruction = {1'b1, buf_we[owner], 1'b0, {SEC_W{1'b0}}};
            ISSUE, BUSY: dev_instruction = {1'b1, op_l, 1'b1, sector_l};
            default:     dev_instruction = '0;
        endcase
    end

    assign dev_addr    = owner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign dev_data_in = owner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    assign rdata       = dev_data_out;

endmodule

// File: tb/tb_disk_arbiter.sv
// Randomized scoreboard bench for disk_arbiter with a small disk_dev stand-in.
module tb_disk_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt, start, op, buf_we, done, err;
    logic [57:0] sector;
    logic [17:0] addr;
    logic [63:0] wdata;
    logic [31:0] rdata, dev_instruction, dev_data_in, dev_data_out;
    logic        dev_read_pause, dev_write_pause, dev_operate_done, dev_abort;
    logic [8:0]  dev_addr;

    disk_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .start(start), .op(op),
        .sector(sector), .buf_we(buf_we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err),
        .dev_instruction(dev_instruction), .dev_read_pause(dev_read_pause),
        .dev_write_pause(dev_write_pause), .dev_addr(dev_addr),
        .dev_data_in(dev_data_in), .dev_data_out(dev_data_out),
        .dev_operate_done(dev_operate_done), .dev_abort(dev_abort)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // disk_dev stand-in: word buffer plus scripted operate_done pulses
    logic [31:0] mem [0:127];
    assign dev_data_out = mem[dev_addr[8:2]];
    always @(posedge clk)
        if (dev_instruction[31:29] == 3'b110) mem[dev_addr[8:2]] <= dev_data_in;

    int resp1 = 0, resp2 = 0;
    initial begin
        int  cnt;
        bit  armed;
        cnt = 0; armed = 0; dev_operate_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 0; dev_operate_done = 1'b0;
            end else if (dev_read_pause || dev_write_pause) begin
                cnt = 0; armed = 1; dev_operate_done = 1'b0;
            end else if (armed) begin
                cnt++;
                dev_operate_done = (cnt == resp1) || (cnt == resp2);
                if (cnt > 60) armed = 0;
            end
        end
    end

    typedef struct {
        logic        owner;
        logic        op;
        logic [28:0] sector;
        int          lat;
        logic        err;
        logic        abort;
    } exp_t;
    exp_t sbq[$];

    // Reference: the first done pulse in BUSY cycles 2..TO completes; otherwise abort on cycle TO.
    function automatic exp_t model(logic o, logic wr, logic [28:0] s, int r1, int r2);
        exp_t e;
        int   k;
        k = TO + 1;
        if (r1 >= 2 && r1 <= TO && r1 < k) k = r1;
        if (r2 >= 2 && r2 <= TO && r2 < k) k = r2;
        e.owner = o; e.op = wr; e.sector = s;
        e.err   = (k > TO);
        e.abort = (k > TO);
        e.lat   = ((k > TO) ? TO : k) + 1;
        return e;
    endfunction

    // Monitor: checks the issue cycle against the queue head, pops on each done pulse.
    initial begin
        exp_t e;
        int   rel;
        bit   active, prev_pause, pause;
        rel = 0; active = 0; prev_pause = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; prev_pause = 0;
            end else begin
                pause = dev_read_pause | dev_write_pause;
                if (pause) begin
                    check("pause_width", 64'(prev_pause), 64'(0));
                    if (sbq.size() == 0) begin
                        check("unexpected_pause", 64'(1), 64'(0));
                    end else begin
                        e = sbq[0];
                        check("write_pause", 64'(dev_write_pause), 64'(e.op));
                        check("read_pause", 64'(dev_read_pause), 64'(!e.op));
                        check("issue_instr", 64'(dev_instruction), 64'({1'b1, e.op, 1'b1, e.sector}));
                        check("err_cleared", 64'(err[e.owner]), 64'(0));
                    end
                    rel = 0; active = 1;
                end else if (active) begin
                    rel++;
                end
                if (done != 2'b00) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        e = sbq.pop_front();
                        check("done_owner", 64'(done), 64'(e.owner ? 2'b10 : 2'b01));
                        check("done_latency", 64'(rel), 64'(e.lat));
                        check("done_err", 64'(err[e.owner]), 64'(e.err));
                        check("done_abort", 64'(dev_abort), 64'(e.abort));
                    end
                    active = 0;
                end else if (dev_abort) begin
                    check("stray_abort", 64'(dev_abort), 64'(0));
                end
                prev_pause = pause;
            end
        end
    end

    logic model_last;
    logic [31:0] ref_mem [0:127];
    int written[$];

    task automatic set_sector(input int o, input logic [28:0] s);
        if (o != 0) sector[57:29] = s; else sector[28:0] = s;
    endtask

    task automatic acquire(input int o);
        bit got;
        @(posedge clk); #1 req[o] = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = gnt[o];
        end
        if (!got) check("grant_timeout", 64'(gnt), 64'(o ? 2'b10 : 2'b01));
        else check("grant_single", 64'(gnt), 64'(o ? 2'b10 : 2'b01));
        model_last = 1'(o);
    endtask

    task automatic release_req(input int o);
        bit got;
        @(posedge clk); #1 req[o] = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (gnt == 2'b00);
        end
        if (!got) check("release_timeout", 64'(gnt), 64'(0));
    endtask

    task automatic buf_write(input int o, input logic [8:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        buf_we[o] = 1'b1;
        addr  = {9'($urandom), 9'($urandom)};
        wdata = {$urandom, $urandom};
        if (o != 0) begin addr[17:9] = a; wdata[63:32] = d; end
        else        begin addr[8:0]  = a; wdata[31:0]  = d; end
        @(negedge clk);
        check("own_instr_we", 64'(dev_instruction), 64'(32'hC000_0000));
        ref_mem[a[8:2]] = d;
        written.push_back(int'(a[8:2]));
        @(posedge clk); #1 buf_we = 2'b00;
    endtask

    task automatic buf_read(input int o, input logic [8:0] a);
        @(posedge clk); #1;
        addr = {9'($urandom), 9'($urandom)};
        if (o != 0) addr[17:9] = a; else addr[8:0] = a;
        @(negedge clk);
        check("own_instr_rd", 64'(dev_instruction), 64'(32'h8000_0000));
        check("rdata", 64'(rdata), 64'(ref_mem[a[8:2]]));
    endtask

    task automatic do_op(input int o, input logic wr, input logic [28:0] s,
                         input int r1, input int r2, input bit drop);
        bit got;
        resp1 = r1; resp2 = r2;
        sbq.push_back(model(1'(o), wr, s, r1, r2));
        @(posedge clk); #1;
        start[o] = 1'b1; op[o] = wr; set_sector(o, s);
        if ($urandom_range(0, 1) == 1) begin
            start[1-o] = 1'b1; op[1-o] = 1'($urandom); set_sector(1 - o, 29'($urandom));
        end
        @(posedge clk); #1 start = 2'b00;
        if (drop) req[o] = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = done[o];
        end
        if (!got) check("done_timeout", 64'(done), 64'(o ? 2'b10 : 2'b01));
        else check("gnt_after_op", 64'(gnt), drop ? 64'(0) : 64'(o ? 2'b10 : 2'b01));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, exp_w, o, sc, r1, r2;
        for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        rst = 1'b1; req = '0; start = '0; op = '0; sector = '0;
        buf_we = '0; addr = '0; wdata = '0;
        model_last = 1'b1;
        #12;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_pauses", 64'({dev_read_pause, dev_write_pause}), 64'(0));
        check("rst_abort", 64'(dev_abort), 64'(0));
        check("rst_instr", 64'(dev_instruction), 64'(0));
        @(negedge clk) rst = 1'b0;

        // Tie-break alternation with both requesters asking continuously
        @(posedge clk); #1 req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            bit got;
            exp_w = model_last ? 0 : 1;
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                got = (gnt != 2'b00);
            end
            check("rr_grant", 64'(gnt), 64'(exp_w ? 2'b10 : 2'b01));
            model_last = 1'(exp_w);
            w = gnt[1] ? 1 : 0;
            @(posedge clk); #1 req[w] = 1'b0;
            @(posedge clk); #1 req[w] = 1'b1;
        end
        @(posedge clk); #1 req = 2'b00;
        repeat (2) @(posedge clk);

        // Buffer access through each owner
        acquire(0);
        buf_write(0, 9'h004, 32'hDEAD_BEEF);
        buf_read(0, 9'h004);
        for (int i = 0; i < 4; i++) buf_write(0, {7'($urandom), 2'b00}, $urandom);
        release_req(0);
        acquire(1);
        for (int i = 0; i < 4; i++) buf_write(1, {7'($urandom), 2'b00}, $urandom);
        for (int i = 0; i < 4; i++) buf_read(1, 9'({written[$urandom_range(0, written.size() - 1)], 2'b00}));
        release_req(1);

        // Directed operations: normal write, timeout with sticky err, stale done, coincident done
        acquire(0);
        do_op(0, 1'b1, 29'h12, 20 > TO ? 10 : 20, 0, 0);
        do_op(0, 1'b0, 29'($urandom), 0, 0, 0);
        @(negedge clk) check("err_sticky", 64'(err[0]), 64'(1));
        buf_write(0, 9'h010, $urandom);
        check("err_sticky_buf", 64'(err[0]), 64'(1));
        do_op(0, 1'b1, 29'($urandom), 1, 7, 0);
        do_op(0, 1'b0, 29'($urandom), TO, 0, 0);
        do_op(0, 1'b1, 29'($urandom), 1, 0, 0);
        release_req(0);

        // Random operations
        for (int n = 0; n < 14; n++) begin
            o  = $urandom_range(0, 1);
            sc = $urandom_range(0, 4);
            r2 = 0;
            case (sc)
                0, 1:    r1 = $urandom_range(2, TO - 1);
                2:       begin r1 = 1; r2 = $urandom_range(3, TO); end
                3:       r1 = TO;
                default: r1 = ($urandom_range(0, 1) == 1) ? 0 : TO + 3;
            endcase
            acquire(o);
            do_op(o, 1'($urandom), 29'($urandom), r1, r2, ($urandom_range(0, 3) == 0));
            if (gnt != 2'b00) release_req(o);
            else repeat (1) @(posedge clk);
        end

        // Asynchronous reset in the middle of BUSY
        acquire(0);
        resp1 = 0; resp2 = 0;
        sbq.push_back(model(1'b0, 1'b1, 29'h5, 0, 0));
        @(posedge clk); #1 start[0] = 1'b1; op[0] = 1'b1; set_sector(0, 29'h5);
        @(posedge clk); #1 start = 2'b00;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gnt", 64'(gnt), 64'(0));
        check("mid_rst_pauses", 64'({dev_read_pause, dev_write_pause}), 64'(0));
        check("mid_rst_abort", 64'(dev_abort), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_instr", 64'(dev_instruction), 64'(0));
        sbq.delete();
        req = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                got = (gnt != 2'b00);
            end
            check("post_rst_grant", 64'(gnt), 64'(2'b01));
        end
        @(posedge clk); #1 req = 2'b00;
        repeat (3) @(posedge clk);
        check("queue_empty", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
